vend_ctrl_param: RTL and testbench

- Parametrised next-generation coin vending controller.
- Accepts nickel/dime/quarter coin events from the debouncers and accumulates credit against a configurable price.
- Locks once credit reaches the price, dispenses on button request, then returns change as a train of unit pulses. Cancel refunds the whole credit.
- Sits between the per-input debouncers and the board LEDs/change actuator in top.

---
 rtl/vend_ctrl_param_if.sv | 26 ++
 rtl/vend_ctrl_param.sv | 160 ++++++++++++++++
 tb/tb_vend_ctrl_param.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/vend_ctrl_param_if.sv
// rtl/vend_ctrl_param_if.sv - coin/button inputs and LED/actuator outputs of the vending controller
interface vend_ctrl_param_if #(
   parameter int CREDIT_W = 7
);
   logic                nickel;
   logic                dime;
   logic                quarter;
   logic                dispense_btn;
   logic                cancel_btn;
   logic [CREDIT_W-1:0] credit;
   logic                locked_led;
   logic                dispense_led;
   logic                change;
   logic                coin_reject;
   logic                busy;

   modport master (
      output nickel, dime, quarter, dispense_btn, cancel_btn,
      input  credit, locked_led, dispense_led, change, coin_reject, busy
   );

   modport slave (
      input  nickel, dime, quarter, dispense_btn, cancel_btn,
      output credit, locked_led, dispense_led, change, coin_reject, busy
   );
endinterface

// File: rtl/vend_ctrl_param.sv
// rtl/vend_ctrl_param.sv - parametrised coin vending controller with change pulse train
module vend_ctrl_param #(
   parameter int CREDIT_W        = 7,
   parameter int PRICE           = 25,
   parameter int NICKEL_VAL      = 5,
   parameter int DIME_VAL        = 10,
   parameter int QUARTER_VAL     = 25,
   parameter int MAX_CREDIT      = 60,
   parameter int CHANGE_UNIT     = 5,
   parameter int PULSE_CYCLES    = 4,
   parameter int DISPENSE_CYCLES = 8
) (
   input logic               clk,
   input logic               rst,
   vend_ctrl_param_if.slave  bus
);
   localparam int TMAX = (PULSE_CYCLES > DISPENSE_CYCLES) ? PULSE_CYCLES : DISPENSE_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);
   localparam logic [CREDIT_W-1:0] NICKEL_C  = CREDIT_W'(NICKEL_VAL);
   localparam logic [CREDIT_W-1:0] DIME_C    = CREDIT_W'(DIME_VAL);
   localparam logic [CREDIT_W-1:0] QUARTER_C = CREDIT_W'(QUARTER_VAL);
   localparam logic [CREDIT_W-1:0] UNIT_C    = CREDIT_W'(CHANGE_UNIT);
   localparam logic [CREDIT_W:0]   MAX_C     = (CREDIT_W+1)'(MAX_CREDIT);
   localparam logic [TW-1:0]       PULSE_END = TW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0]       VEND_END  = TW'(DISPENSE_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDING, S_LOCKED, S_VEND, S_CHANGE
   } state_t;

   state_t              state, state_n;
   logic [CREDIT_W-1:0] credit_r, credit_n;
   logic [TW-1:0]       timer, timer_n;
   logic                change_r, change_n;
   logic                reject_r, reject_n;
   logic                nickel_q, dime_q, quarter_q, dispense_q, cancel_q;

   logic                ev_nickel, ev_dime, ev_quarter, ev_dispense, ev_cancel;
   logic                any_coin, multi_coin, accept;
   logic [CREDIT_W-1:0] coin_val;
   logic [CREDIT_W:0]   credit_sum;

   assign ev_nickel   = bus.nickel       & ~nickel_q;
   assign ev_dime     = bus.dime         & ~dime_q;
   assign ev_quarter  = bus.quarter      & ~quarter_q;
   assign ev_dispense = bus.dispense_btn & ~dispense_q;
   assign ev_cancel   = bus.cancel_btn   & ~cancel_q;

   assign any_coin   = ev_nickel | ev_dime | ev_quarter;
   assign multi_coin = (ev_nickel & ev_dime) | (ev_nickel & ev_quarter) | (ev_dime & ev_quarter);
   assign coin_val   = ev_quarter ? QUARTER_C : (ev_dime ? DIME_C : (ev_nickel ? NICKEL_C : '0));
   assign credit_sum = {1'b0, credit_r} + {1'b0, coin_val};

   // A cancel in ADDING takes precedence, so the coin of that cycle is refused.
   assign accept = any_coin && (credit_sum <= MAX_C) &&
                   ((state == S_IDLE) || ((state == S_ADDING) && !ev_cancel));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= S_IDLE;
         credit_r   <= '0;
         timer      <= '0;
         change_r   <= 1'b0;
         reject_r   <= 1'b0;
         nickel_q   <= 1'b0;
         dime_q     <= 1'b0;
         quarter_q  <= 1'b0;
         dispense_q <= 1'b0;
         cancel_q   <= 1'b0;
      end else begin
         state      <= state_n;
         credit_r   <= credit_n;
         timer      <= timer_n;
         change_r   <= change_n;
         reject_r   <= reject_n;
         nickel_q   <= bus.nickel;
         dime_q     <= bus.dime;
         quarter_q  <= bus.quarter;
         dispense_q <= bus.dispense_btn;
         cancel_q   <= bus.cancel_btn;
      end
   end

   always_comb begin
      state_n  = state;
      credit_n = credit_r;
      timer_n  = timer;
      change_n = change_r;
      reject_n = any_coin && (!accept || multi_coin);

      case (state)
         S_IDLE: begin
            if (accept) begin
               credit_n = coin_val;
               state_n  = S_ADDING;
            end
         end
         S_ADDING: begin
            if (ev_cancel) begin
               state_n  = S_CHANGE;
               timer_n  = '0;
               change_n = 1'b1;
            end else begin
               if (accept) credit_n = credit_sum[CREDIT_W-1:0];
               if (credit_r >= PRICE_C) state_n = S_LOCKED;
            end
         end
         S_LOCKED: begin
            if (ev_dispense) begin
               credit_n = credit_r - PRICE_C;
               state_n  = S_VEND;
               timer_n  = '0;
            end else if (ev_cancel) begin
               state_n  = S_CHANGE;
               timer_n  = '0;
               change_n = 1'b1;
            end
         end
         S_VEND: begin
            if (timer == VEND_END) begin
               timer_n = '0;
               if (credit_r != '0) begin
                  state_n  = S_CHANGE;
                  change_n = 1'b1;
               end else begin
                  state_n = S_IDLE;
               end
            end else begin
               timer_n = timer + 1'b1;
            end
         end
         S_CHANGE: begin
            // Each unit is a high phase then a low phase; credit drops as the pulse falls.
            if (timer != PULSE_END) begin
               timer_n = timer + 1'b1;
            end else if (change_r) begin
               timer_n  = '0;
               change_n = 1'b0;
               credit_n = credit_r - UNIT_C;
            end else if (credit_r == '0) begin
               timer_n = '0;
               state_n = S_IDLE;
            end else begin
               timer_n  = '0;
               change_n = 1'b1;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.credit       = credit_r;
   assign bus.locked_led   = (state == S_LOCKED);
   assign bus.dispense_led = (state == S_VEND);
   assign bus.change       = change_r;
   assign bus.coin_reject  = reject_r;
   assign bus.busy         = (state == S_VEND) || (state == S_CHANGE);
endmodule

// File: tb/tb_vend_ctrl_param.sv
// tb/tb_vend_ctrl_param.sv - scoreboard bench for vend_ctrl_param against a cycle reference model
module tb_vend_ctrl_param;
   localparam int CW     = 7;
   localparam int PRICE  = 25;
   localparam int MAXC   = 60;
   localparam int UNIT   = 5;
   localparam int PCYC   = 4;
   localparam int DCYC   = 8;
   localparam int I_N = 0, I_D = 1, I_Q = 2, I_DISP = 3, I_CAN = 4;
   localparam int M_IDLE = 0, M_ADD = 1, M_LOCK = 2, M_VEND = 3, M_CHG = 4;

   typedef struct {
      int          e;
      logic [11:0] v;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   vend_ctrl_param_if #(.CREDIT_W(CW)) bus ();

   vend_ctrl_param #(.CREDIT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int   edge_cnt = 0;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   logic [4:0] s_in = '0;
   logic       s_rst = 1'b0;

   // Reference model: spec rules over plain integers
   int         m_mode = M_IDLE, m_cr = 0, m_tick = 0;
   logic [4:0] m_prev = '0;
   logic       m_rej = 1'b0;

   task automatic model_step(input logic r, input logic [4:0] in);
      logic [4:0] ev;
      int         ncoin, val, old;
      bit         ok;
      if (!r) begin
         m_mode = M_IDLE; m_cr = 0; m_tick = 0; m_prev = '0; m_rej = 1'b0;
         return;
      end
      ev     = in & ~m_prev;
      m_prev = in;
      ncoin  = int'(ev[I_N]) + int'(ev[I_D]) + int'(ev[I_Q]);
      val    = ev[I_Q] ? 25 : (ev[I_D] ? 10 : (ev[I_N] ? 5 : 0));
      ok     = (ncoin > 0) && (m_cr + val <= MAXC) &&
               (m_mode == M_IDLE || (m_mode == M_ADD && !ev[I_CAN]));
      m_rej  = (ncoin > 1) || (ncoin > 0 && !ok);
      case (m_mode)
         M_IDLE: if (ok) begin m_cr = val; m_mode = M_ADD; end
         M_ADD: begin
            if (ev[I_CAN]) begin
               m_mode = M_CHG; m_tick = 0;
            end else begin
               old = m_cr;
               if (ok) m_cr = m_cr + val;
               if (old >= PRICE) m_mode = M_LOCK;
            end
         end
         M_LOCK: begin
            if (ev[I_DISP]) begin m_cr = m_cr - PRICE; m_mode = M_VEND; m_tick = 0; end
            else if (ev[I_CAN]) begin m_mode = M_CHG; m_tick = 0; end
         end
         M_VEND: begin
            if (m_tick == DCYC - 1) begin
               m_tick = 0;
               m_mode = (m_cr != 0) ? M_CHG : M_IDLE;
            end else m_tick++;
         end
         default: begin
            m_tick++;
            if (m_tick == PCYC) m_cr = m_cr - UNIT;
            if (m_tick == 2 * PCYC) begin
               m_tick = 0;
               if (m_cr == 0) m_mode = M_IDLE;
            end
         end
      endcase
   endtask

   function automatic logic [11:0] model_out();
      logic chg;
      chg = (m_mode == M_CHG) && (m_tick < PCYC);
      return {CW'(m_cr), m_mode == M_LOCK, m_mode == M_VEND, chg, m_rej,
              (m_mode == M_VEND) || (m_mode == M_CHG)};
   endfunction

   task automatic step(input int n);
      exp_t x;
      repeat (n) begin
         @(posedge clk);
         #1;
         rst              = s_rst;
         bus.nickel       = s_in[I_N];
         bus.dime         = s_in[I_D];
         bus.quarter      = s_in[I_Q];
         bus.dispense_btn = s_in[I_DISP];
         bus.cancel_btn   = s_in[I_CAN];
         model_step(s_rst, s_in);
         x.e = edge_cnt + 1;
         x.v = model_out();
         sb.push_back(x);
      end
   endtask

   task automatic press(input int idx, input int hold, input int gap);
      s_in[idx] = 1'b1;
      step(hold);
      s_in[idx] = 1'b0;
      step(gap);
   endtask

   // Monitor: pops the expectation belonging to the edge just taken
   initial begin
      exp_t        x;
      logic [11:0] act;
      forever begin
         @(negedge clk);
         while (sb.size() > 0 && sb[0].e <= edge_cnt) begin
            x   = sb.pop_front();
            act = {bus.credit, bus.locked_led, bus.dispense_led, bus.change,
                   bus.coin_reject, bus.busy};
            n_cmp++;
            if (act !== x.v) begin
               n_fail++;
               $display("FAIL outputs edge %0d: got credit=%0d lk=%b dl=%b ch=%b rj=%b bz=%b, want credit=%0d lk=%b dl=%b ch=%b rj=%b bz=%b",
                        x.e, act[11:5], act[4], act[3], act[2], act[1], act[0],
                        x.v[11:5], x.v[4], x.v[3], x.v[2], x.v[1], x.v[0]);
            end
         end
      end
   end

   initial begin
      bus.nickel = 1'b0; bus.dime = 1'b0; bus.quarter = 1'b0;
      bus.dispense_btn = 1'b0; bus.cancel_btn = 1'b0;
      s_rst = 1'b0;
      step(3);
      s_rst = 1'b1;
      step(3);

      // dime, dime, nickel then dispense with no change
      press(I_D, 1, 9); press(I_D, 1, 9); press(I_N, 1, 9);
      press(I_DISP, 1, 20);
      // three dimes, refused fourth, dispense with one change pulse
      press(I_D, 1, 9); press(I_D, 1, 9); press(I_D, 1, 9); press(I_D, 1, 9);
      press(I_DISP, 1, 30);
      // simultaneous nickel+dime, then a long-held dime
      s_in[I_N] = 1'b1; s_in[I_D] = 1'b1; step(1);
      s_in[I_N] = 1'b0; step(50);
      s_in[I_D] = 1'b0; step(5);
      press(I_CAN, 1, 30);
      // 15 cents cancelled
      press(I_D, 1, 5); press(I_N, 1, 5); press(I_CAN, 1, 40);
      // quarter cancelled in LOCKED, then dispense+cancel together
      press(I_Q, 1, 5); press(I_CAN, 1, 50);
      press(I_Q, 1, 5);
      s_in[I_DISP] = 1'b1; s_in[I_CAN] = 1'b1; step(1);
      s_in[I_DISP] = 1'b0; s_in[I_CAN] = 1'b0; step(20);
      // reset during the second pulse of a 30-cent refund
      press(I_D, 1, 4); press(I_D, 1, 4); press(I_D, 1, 4);
      press(I_CAN, 1, 11);
      s_rst = 1'b0; step(1);
      s_rst = 1'b1; step(30);

      // randomized levels with rare resets
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(5) == 0) s_in[I_N]    = ~s_in[I_N];
         if ($urandom_range(5) == 0) s_in[I_D]    = ~s_in[I_D];
         if ($urandom_range(7) == 0) s_in[I_Q]    = ~s_in[I_Q];
         if ($urandom_range(9) == 0) s_in[I_DISP] = ~s_in[I_DISP];
         if ($urandom_range(39) == 0) s_in[I_CAN] = ~s_in[I_CAN];
         s_rst = ($urandom_range(799) != 0);
         step(1);
      end
      s_in = '0; s_rst = 1'b1;
      step(5);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      #1;
      if (sb.size() > 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
